// File: rtl/iomem_pwm_led_if.sv
// PicoSoC iomem bus bundle between a bus master and the PWM LED slave.
// Latency: none (plain wires).
// Backpressure: the master holds iomem_valid until the slave pulses iomem_ready.
//
// Ports (signals carried):
//   iomem_valid  master->slave  request valid
//   iomem_wstrb  master->slave  byte write strobes, 0 = read
//   iomem_addr   master->slave  byte address
//   iomem_wdata  master->slave  write data
//   iomem_ready  slave->master  one-cycle acknowledge
//   iomem_rdata  slave->master  read data, 0 while iomem_ready is 0
interface iomem_pwm_led_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_pwm_led.sv
// 4-channel PWM LED controller on the PicoSoC iomem bus, driving the user/RGB LED pins.
// Latency: bus ack and read data one cycle after accept; led lags the counter compare by one cycle.
// Backpressure: none; every request on this page is acked after one cycle, with an idle cycle forced between accepts.
//
// Ports:
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     iomem slave modport (valid/wstrb/addr/wdata in, ready/rdata out)
//   led     registered PWM outputs, active high
//
// Register map (addr[3:2]):
//   0x0 CTRL   bit0 EN, bits[7:4] INV
//   0x4 PRESC  bits[15:0] prescaler reload
//   0x8 DUTY   byte i = shadow duty of channel i
//   0xC STATUS bits[7:0] pwm_cnt (RO), bit8 WRAP (sticky, write-1-to-clear)
module iomem_pwm_led #(
  parameter logic [7:0]  ADDR_PAGE   = 8'h04,
  parameter logic [15:0] PRESC_RESET = 16'd46
) (
  input  logic           clk,
  input  logic           resetn,
  iomem_pwm_led_if.slave bus,
  output logic [3:0]     led
);

  // Programmable state
  logic        en;
  logic [3:0]  inv;
  logic [15:0] presc;
  logic [31:0] duty;       // shadow, as written by software
  logic [31:0] duty_act;   // what the comparators actually use
  logic        wrap_flag;

  // Counters
  logic [15:0] presc_cnt;
  logic [7:0]  pwm_cnt;

  // Bus decode
  logic        accept;
  logic        is_write;
  logic [1:0]  sel;
  logic [31:0] wmask;
  logic [31:0] rd_val;
  logic        clr_wrap;

  // Counter events and output compare
  logic        tick;
  logic        wrap_evt;
  logic [3:0]  led_nxt;

  // Only page and register-select bits of the address take part in decode.
  logic        unused_addr;
  assign unused_addr = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

  // The !ready term stops a still-asserted valid from being accepted twice.
  assign accept   = bus.iomem_valid && !bus.iomem_ready &&
                    (bus.iomem_addr[31:24] == ADDR_PAGE);
  assign is_write = accept && (bus.iomem_wstrb != 4'b0000);
  assign sel      = bus.iomem_addr[3:2];
  assign wmask    = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                     {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
  assign clr_wrap = is_write && (sel == 2'd3) && bus.iomem_wstrb[1] &&
                    bus.iomem_wdata[8];

  // Read mux sees register values before any write in the same access.
  always_comb begin
    rd_val = '0;
    case (sel)
      2'd0: rd_val = {24'd0, inv, 3'd0, en};
      2'd1: rd_val = {16'd0, presc};
      2'd2: rd_val = duty;
      2'd3: rd_val = {23'd0, wrap_flag, pwm_cnt};
      default: rd_val = '0;
    endcase
  end

  // Bus response: rdata is forced to 0 outside the ack so the top level can OR slaves.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
    end else begin
      bus.iomem_ready <= accept;
      bus.iomem_rdata <= accept ? rd_val : '0;
    end
  end

  // Register writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en    <= 1'b0;
      inv   <= 4'd0;
      presc <= PRESC_RESET;
      duty  <= '0;
    end else if (is_write) begin
      case (sel)
        2'd0: begin
          if (bus.iomem_wstrb[0]) begin
            en  <= bus.iomem_wdata[0];
            inv <= bus.iomem_wdata[7:4];
          end
        end
        2'd1: presc <= (presc & ~wmask[15:0]) | (bus.iomem_wdata[15:0] & wmask[15:0]);
        2'd2: duty  <= (duty & ~wmask) | (bus.iomem_wdata & wmask);
        default: ;
      endcase
    end
  end

  // Prescaler and PWM counter. A presc_cnt left above a freshly lowered
  // PRESC would otherwise run to 65535 before ticking, so it is restarted.
  assign tick     = en && (presc_cnt == presc);
  assign wrap_evt = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (!resetn || !en) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (presc_cnt > presc) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 8'd1;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  // Sticky WRAP: a wrap in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrap_flag <= 1'b0;
    end else if (wrap_evt) begin
      wrap_flag <= 1'b1;
    end else if (clr_wrap) begin
      wrap_flag <= 1'b0;
    end
  end

  // Active duty only changes at a period boundary, so a running period is
  // never cut short or stretched. A DUTY write landing on the wrap edge is
  // not seen here until the following wrap (non-blocking read of old duty).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      duty_act <= '0;
    end else if (!en || wrap_evt) begin
      duty_act <= duty;
    end
  end

  always_comb begin
    led_nxt = inv;
    for (int i = 0; i < 4; i++) begin
      led_nxt[i] = (en && (pwm_cnt < duty_act[8*i +: 8])) ^ inv[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= 4'd0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: doc/iomem_pwm_led.md
# iomem_pwm_led

Memory-mapped 4-channel PWM LED controller on the PicoSoC iomem bus. It sits beside the GPIO register in the board top level and drives the user LED and RGB LED pins with programmable brightness instead of plain on/off. It decodes its own address page, answers reads and writes with a single-cycle ready pulse, and produces glitch-free PWM from a prescaled 8-bit counter.

## Interface
Parameters:
- ADDR_PAGE, 8'h04, value of iomem_addr[31:24] that selects this block.
- PRESC_RESET, 16'd46, reset value of the PRESC register; gives ~1 kHz PWM at 12 MHz.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- iomem_valid  in  1  bus request valid.
- iomem_wstrb  in  4  byte write strobes; 0 means read.
- iomem_addr  in  32  byte address; [31:24] page, [3:2] register select.
- iomem_wdata  in  32  write data.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_rdata  out  32  read data; 0 whenever iomem_ready is 0, so the top level can OR-combine it with other slaves.
- led  out  4  PWM outputs, active high, registered.

## Operation
Registers are selected by addr[3:2]. Byte strobes apply to all writable bytes.
- 0x0 CTRL:
  - bit0 EN.
  - bits[7:4] INV, per-channel output invert.
  - Other bits read 0.
- 0x4 PRESC: bits[15:0] prescaler reload. Bits[31:16] read 0.
- 0x8 DUTY: byte i is the duty for channel i. This is a shadow register, read back as written.
- 0xC STATUS:
  - bits[7:0] current pwm_cnt, read-only.
  - bit8 WRAP, sticky. Writing 1 to bit8 (wstrb[1]) clears it.

Bus handshake:
- The block accepts a request when iomem_valid && !iomem_ready && addr[31:24]==ADDR_PAGE.
- Other pages are ignored: no ready, no state change.

Prescaler and counter:
- presc_cnt counts 0..PRESC. When presc_cnt==PRESC it generates a tick and reloads to 0.
- pwm_cnt (8 bit) increments on each tick and wraps 255→0. The wrap sets WRAP.
- If presc_cnt > PRESC after a write, presc_cnt resets to 0 on the next cycle.

Duty buffering:
- Each active duty is loaded from the shadow DUTY on wrap.
- While EN=0, active duty follows the shadow continuously.

Output equation, per channel i:
- led[i] <= (EN && pwm_cnt < duty_act[i]) ^ INV[i].
- Duty 0 gives always off (before invert). Duty 255 gives 255/256 on.

EN=0 behaviour:
- presc_cnt and pwm_cnt are held at 0.
- led = INV.

Boundary cases:
- Wrap and a WRAP-clear write in the same cycle: set wins.
- A DUTY write in the same cycle as a wrap: the old shadow value is loaded, and the new value takes effect at the next wrap.
- A PRESC write takes effect from the next presc_cnt comparison.

## Timing
- Reset, synchronous on resetn=0:
  - iomem_ready=0, iomem_rdata=0, led=0.
  - CTRL=0, DUTY=0, duty_act=0, PRESC=PRESC_RESET.
  - presc_cnt=0, pwm_cnt=0, WRAP=0.
- Access accepted at edge t: iomem_ready=1 and iomem_rdata valid during cycle t+1.
  - Register writes are visible from t+1.
  - iomem_ready is 1 for exactly one cycle.
  - Reads return the pre-write value.
- Back-to-back: the !iomem_ready guard forces at least one idle cycle between accepts.
- led lags the pwm_cnt/duty_act comparison by 1 cycle.
- PWM period = 256·(PRESC+1) clk cycles.
- resetn asserted mid-access: ready is dropped on the next edge and no write is completed.

## Test plan
- Reset: hold resetn=0 for 4 cycles. Expect led=0, ready=0, rdata=0. A read of PRESC returns 46 and a read of CTRL returns 0.
- Register R/W with strobes:
  - Write DUTY=0x11223344 with wstrb=4'b0101, then read. Expect 0x00220044.
  - Read of a page 0x03 address: no ready from this block.
  - Ready lasts exactly 1 cycle.
- PWM duty: PRESC=0, DUTY byte0=64, CTRL=0x1. Expect led[0] high for exactly 64 of every 256 cycles, and the period measured edge-to-edge is 256 cycles.
- Glitch-free update: with duty 64 running, write duty 200 at pwm_cnt≈100. Expect the current period still ends its high time at count 64, and the next period is high for 200 cycles.
- WRAP flag:
  - PRESC=1. After 512 cycles, STATUS bit8=1.
  - Write 0x100 clears it.
  - A clear write coinciding with a wrap leaves bit8=1.
- Disable/invert: CTRL=0xA0 (EN=0, INV=1010). Expect led=4'b1010 steady, pwm_cnt reads 0, and a DUTY write is reflected immediately after re-enable.
